// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of one shared compare unit.
// Grant in IDLE, drive registered operands in ISSUE, hold the response in RESP.
module cmp_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req0_A,
   input  logic [WIDTH-1:0] req0_B,
   input  logic [WIDTH-1:0] req1_A,
   input  logic [WIDTH-1:0] req1_B,
   input  logic [2:0]       req0_FT,
   input  logic [2:0]       req1_FT,
   output logic [WIDTH-1:0] cmp_A,
   output logic [WIDTH-1:0] cmp_B,
   output logic [2:0]       cmp_FT,
   input  logic             cmp_S,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic             rsp_S,
   output logic             rsp_err,
   input  logic             rsp_ready
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e           r_state;
   logic             r_last;
   logic             r_id;
   logic [WIDTH-1:0] r_cmp_a;
   logic [WIDTH-1:0] r_cmp_b;
   logic [2:0]       r_cmp_ft;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic             r_rsp_s;
   logic             r_rsp_err;

   logic w_idle;
   logic w_grant0;
   logic w_grant1;
   logic w_illegal;

   // r_last is the id granted most recently; reset value 1 gives requester 0 priority.
   assign w_idle    = (r_state == StIdle);
   assign w_grant0  = w_idle & req0_valid & (~req1_valid | r_last);
   assign w_grant1  = w_idle & req1_valid & (~req0_valid | ~r_last);
   assign w_illegal = (r_cmp_ft == 3'b011) | (r_cmp_ft == 3'b101);

   // Ready is gated by reset so it drops immediately while reset is held.
   assign req0_ready = w_grant0 & ~reset;
   assign req1_ready = w_grant1 & ~reset;

   assign cmp_A     = r_cmp_a;
   assign cmp_B     = r_cmp_b;
   assign cmp_FT    = r_cmp_ft;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_S     = r_rsp_s;
   assign rsp_err   = r_rsp_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StIdle;
         r_last      <= 1'b1;
         r_id        <= 1'b0;
         r_cmp_a     <= '0;
         r_cmp_b     <= '0;
         r_cmp_ft    <= 3'b000;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_s     <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_grant0 | w_grant1) begin
                  r_cmp_a  <= w_grant1 ? req1_A  : req0_A;
                  r_cmp_b  <= w_grant1 ? req1_B  : req0_B;
                  r_cmp_ft <= w_grant1 ? req1_FT : req0_FT;
                  r_id     <= w_grant1;
                  r_last   <= w_grant1;
                  r_state  <= StIssue;
               end
            end
            StIssue: begin
               r_rsp_valid <= 1'b1;
               r_rsp_id    <= r_id;
               r_rsp_s     <= cmp_S & ~w_illegal;
               r_rsp_err   <= w_illegal;
               r_state     <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_id    <= 1'b0;
                  r_rsp_s     <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n has a compare pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester n's request is accepted this cycle.
REQ-006 SHALL have ports req0_A, req0_B / req1_A, req1_B  input  WIDTH  compare operands.
REQ-007 SHALL have ports req0_FT / req1_FT  input  3  compare function: 001 EQ, 000 NEQ, 010 LT, 110 LEZ, 100 GEZ, 111 GTZ.
REQ-008 SHALL have ports cmp_A, cmp_B  output  WIDTH  operands driven to the shared subtract/compare unit.
REQ-009 SHALL have port cmp_FT  output  3  function code driven to the shared unit.
REQ-010 SHALL have port cmp_S  input  1  combinational compare result from the shared unit.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_id  output  1, rsp_S  output  1, rsp_err  output  1: result handshake, owner id, result, illegal-FT flag.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts the response.

Function
REQ-013 SHALL arbitrate two requesters for one shared compare unit using a three-state FSM: IDLE, ISSUE, RESP.
REQ-014 In IDLE with any reqN_valid, SHALL grant exactly one requester: pulse reqN_ready for one cycle, register A, B, FT and the id, and go to ISSUE.
REQ-015 On simultaneous valid, SHALL grant the requester not granted last (round-robin); after reset, requester 0 has priority.
REQ-016 With a single valid requester, SHALL grant it regardless of the round-robin pointer.
REQ-017 reqN_ready SHALL be 0 in ISSUE and RESP; requests presented then are held by the requester, not dropped.
REQ-018 cmp_A, cmp_B and cmp_FT SHALL come from registers and stay stable from ISSUE entry until the next grant; all three SHALL be 0 after reset.
REQ-019 In ISSUE, SHALL capture cmp_S into rsp_S at the clock edge and go to RESP; request-to-response latency is 2 cycles after the grant edge.
REQ-020 FT codes 011 and 101 are illegal: SHALL force rsp_S=0 and rsp_err=1 and ignore cmp_S; legal codes give rsp_err=0.
REQ-021 In RESP, rsp_valid SHALL be 1; rsp_id, rsp_S and rsp_err SHALL hold stable until the rsp_ready=1 edge, then return to IDLE.
REQ-022 SHALL not start a new grant in the cycle a response retires; the earliest new grant is the following IDLE cycle. Throughput is 1 compare per 3 cycles with no backpressure.
REQ-023 SHALL update the round-robin pointer only on a grant.
REQ-024 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-025 Asserting reset in any state SHALL immediately force IDLE, all ready/rsp outputs to 0, cmp_* to 0 and the pointer to favour requester 0; an in-flight request is discarded.
REQ-026 After reset deasserts, the first rising edge with a valid request SHALL be able to grant.

Verification
REQ-027 Single request: req0 A=5, B=5, FT=001, cmp_S model=1 -> req0_ready pulses, rsp_valid two cycles later with rsp_id=0, rsp_S=1, rsp_err=0.
REQ-028 Contention: req0 and req1 both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1, each response is tagged with the correct id, one grant every 3 cycles.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_S stay constant, req1_ready stays 0; after rsp_ready=1, grant in the following IDLE cycle.
REQ-030 Illegal FT: req1 FT=011, cmp_S=1 -> rsp_S=0, rsp_err=1, rsp_id=1.
REQ-031 Reset mid-operation: reset asserted in ISSUE -> all outputs 0 asynchronously; after release with both requesters valid, requester 0 is granted first.
REQ-032 Operand stability: change req0_A after grant -> cmp_A keeps the granted value until the next grant.
